// File: rtl/seu_counter_pkg.sv
// Shared helpers for the SEU counter bank: select-width sizing, saturating
// arithmetic and population count used by the channel and total counters.
package seu_counter_pkg;

    // One extra select code above the channels addresses the total counter.
    function automatic int sel_w(input int nch);
        return ($clog2(nch + 1) < 1) ? 1 : $clog2(nch + 1);
    endfunction

    function automatic int total_sel(input int nch);
        return nch;
    endfunction

    function automatic logic [31:0] sat_max(input int unsigned w);
        return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    endfunction

    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                            input int unsigned w);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s > {1'b0, sat_max(w)})
            return sat_max(w);
        return s[31:0];
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] a, input int unsigned w);
        return sat_add(a, 32'd1, w);
    endfunction

    function automatic logic [5:0] popcount(input logic [31:0] v);
        logic [5:0] n;
        n = '0;
        for (int i = 0; i < 32; i++)
            n = n + {5'd0, v[i]};
        return n;
    endfunction

endpackage

// File: rtl/seu_counter_bank_if.sv
// Read port of the SEU counter bank: one request in, one registered response out.
interface seu_counter_bank_if import seu_counter_pkg::*; #(
    parameter int NCH  = 4,
    parameter int TOTW = 16
);
    localparam int SELW = sel_w(NCH);

    logic            rd_req;
    logic [SELW-1:0] rd_sel;
    logic            rd_valid;
    logic [TOTW-1:0] rd_data;
    logic            rd_ovf;

    modport master (output rd_req, rd_sel, input rd_valid, rd_data, rd_ovf);
    modport slave  (input rd_req, rd_sel, output rd_valid, rd_data, rd_ovf);
endinterface

// File: rtl/seu_counter_chan.sv
// One error channel: edge/level event detect, saturating counter and sticky
// saturation flag, with bank clear and read-clear that keeps a coincident event.
module seu_counter_chan import seu_counter_pkg::*; #(
    parameter int CNTW      = 8,
    parameter bit EDGE_MODE = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            err,
    input  logic            cnt_en,
    input  logic            clr_all,
    input  logic            rd_clr,
    output logic            evt,
    output logic [CNTW-1:0] cnt,
    output logic            ovf
);
    localparam logic [CNTW-1:0] CNT_MAX = CNTW'(sat_max(CNTW));

    logic            err_q, err_d;
    logic [CNTW-1:0] cnt_q, cnt_d, cnt_inc;
    logic            ovf_q, ovf_d;

    always_comb begin
        // Edge history tracks err even while counting is disabled.
        err_d   = err;
        evt     = cnt_en & (EDGE_MODE ? (err & ~err_q) : err);
        cnt_inc = CNTW'(sat_inc(32'(cnt_q), CNTW));
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        if (clr_all) begin
            cnt_d = '0;
            ovf_d = 1'b0;
        end else if (rd_clr) begin
            cnt_d = CNTW'(evt);
            ovf_d = 1'b0;
        end else if (evt) begin
            cnt_d = cnt_inc;
            ovf_d = ovf_q | (cnt_inc == CNT_MAX);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            err_q <= err_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    assign cnt = cnt_q;
    assign ovf = ovf_q;
endmodule

// File: rtl/seu_counter_bank.sv
// Bank of per-domain TMR error counters plus a saturating total, a sticky
// any-error flag and a one-cycle-latency read port with optional clear-on-read.
module seu_counter_bank import seu_counter_pkg::*; #(
    parameter int NCH           = 4,
    parameter int CNTW          = 8,
    parameter int TOTW          = 16,
    parameter bit EDGE_MODE     = 1'b1,
    parameter bit CLEAR_ON_READ = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NCH-1:0]     err,
    input  logic [NCH-1:0]     cnt_en,
    input  logic               clr_all,
    seu_counter_bank_if.slave  rd_if,
    output logic               any_err,
    output logic [NCH-1:0]     ovf
);
    localparam int              SELW    = sel_w(NCH);
    localparam logic [SELW-1:0] TOT_SEL = SELW'(total_sel(NCH));
    localparam logic [TOTW-1:0] TOT_MAX = TOTW'(sat_max(TOTW));

    logic [NCH-1:0]  evt;
    logic [NCH-1:0]  rd_clr;
    logic [CNTW-1:0] cnt [NCH];
    logic [5:0]      n_evt;
    logic            tot_clr;
    logic [TOTW-1:0] tot_base, tot_sum;

    logic [TOTW-1:0] total_q, total_d;
    logic            tovf_q, tovf_d;
    logic            any_err_q, any_err_d;
    logic            rd_valid_q, rd_valid_d;
    logic [TOTW-1:0] rd_data_q, rd_data_d, sel_data;
    logic            rd_ovf_q, rd_ovf_d, sel_ovf;

    for (genvar g = 0; g < NCH; g++) begin : g_chan
        seu_counter_chan #(
            .CNTW      (CNTW),
            .EDGE_MODE (EDGE_MODE)
        ) u_chan (
            .clk     (clk),
            .rst     (rst),
            .err     (err[g]),
            .cnt_en  (cnt_en[g]),
            .clr_all (clr_all),
            .rd_clr  (rd_clr[g]),
            .evt     (evt[g]),
            .cnt     (cnt[g]),
            .ovf     (ovf[g])
        );
    end

    always_comb begin
        for (int i = 0; i < NCH; i++)
            rd_clr[i] = CLEAR_ON_READ && rd_if.rd_req && (rd_if.rd_sel == SELW'(i));
        tot_clr = CLEAR_ON_READ && rd_if.rd_req && (rd_if.rd_sel == TOT_SEL);

        // Total counts every qualified event, even on channels already saturated.
        n_evt    = popcount(32'(evt));
        tot_base = tot_clr ? '0 : total_q;
        tot_sum  = TOTW'(sat_add(32'(tot_base), 32'(n_evt), TOTW));
        total_d  = total_q;
        tovf_d   = tovf_q;
        if (clr_all) begin
            total_d = '0;
            tovf_d  = 1'b0;
        end else if (tot_clr) begin
            total_d = tot_sum;
            tovf_d  = (n_evt != 6'd0) && (tot_sum == TOT_MAX);
        end else if (n_evt != 6'd0) begin
            total_d = tot_sum;
            tovf_d  = tovf_q | (tot_sum == TOT_MAX);
        end
        any_err_d = clr_all ? 1'b0 : (any_err_q | (|evt));

        // Out-of-range selects return zero without clearing anything.
        sel_data = '0;
        sel_ovf  = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (rd_if.rd_sel == SELW'(i)) begin
                sel_data = TOTW'(cnt[i]);
                sel_ovf  = ovf[i];
            end
        end
        if (rd_if.rd_sel == TOT_SEL) begin
            sel_data = total_q;
            sel_ovf  = tovf_q;
        end
        rd_valid_d = rd_if.rd_req;
        rd_data_d  = rd_if.rd_req ? sel_data : rd_data_q;
        rd_ovf_d   = rd_if.rd_req ? sel_ovf  : rd_ovf_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            total_q    <= '0;
            tovf_q     <= 1'b0;
            any_err_q  <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            rd_ovf_q   <= 1'b0;
        end else begin
            total_q    <= total_d;
            tovf_q     <= tovf_d;
            any_err_q  <= any_err_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            rd_ovf_q   <= rd_ovf_d;
        end
    end

    assign any_err        = any_err_q;
    assign rd_if.rd_valid = rd_valid_q;
    assign rd_if.rd_data  = rd_data_q;
    assign rd_if.rd_ovf   = rd_ovf_q;
endmodule
